memory_arbiter: RTL
===================

# memory_arbiter

Two-requester arbiter that shares the single-ported unified instruction/data memory between the CPU's instruction-fetch unit and its load/store unit. It drives the memory's address, write-enable and write-data inputs, and samples its combinational read output. It returns registered responses one cycle after each grant. Data accesses take priority, and an optional anti-starvation counter bounds how long a fetch can be held off.

## Interface
- addresswidth, 32, word-address width of both request ports and of mem_address
- width, 32, data word width
- MAX_WAIT, 3, consecutive lost arbitration cycles after which a pending fetch wins (≥1; used only with fairness enabled)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  addresswidth  fetch word address
- ireq_ready  out  1  fetch request granted this cycle
- iresp_valid  out  1  fetch data valid
- iresp_data  out  width  fetched instruction word
- dreq_valid  in  1  data request pending
- dreq_we  in  1  1 = store, 0 = load
- dreq_addr  in  addresswidth  data word address
- dreq_wdata  in  width  store data
- dreq_ready  out  1  data request granted this cycle
- dresp_valid  out  1  load data, or store acknowledge, valid
- dresp_data  out  width  load data; 0 for a store acknowledge
- mem_address  out  addresswidth  to memory address
- mem_writeEnable  out  1  to memory write enable
- mem_dataIn  out  width  to memory write data
- mem_dataOut  in  width  from memory combinational read data

## Operation
- Handshake: a request transfers when valid && ready in the same cycle. The requester holds valid and payload stable until it sees ready.
- ready is combinational from the valids and the fairness state. At most one ready is high per cycle.
- Grant rule without fairness: dreq_valid wins. ireq_ready = ireq_valid && !dreq_valid.
- Grant rule with fairness: if wait_cnt == MAX_WAIT and ireq_valid, the fetch wins. Otherwise the data request wins.
- Memory drive, combinational from the grant:
  - mem_address = granted address; it holds the data address when no request is granted.
  - mem_writeEnable = dreq_ready && dreq_we; it is never high without a data grant.
  - mem_dataIn = dreq_wdata.
- Response registers, updated on the posedge after a grant:
  - A fetch grant produces iresp_valid = 1 and iresp_data = mem_dataOut.
  - A load grant produces dresp_valid = 1 and dresp_data = mem_dataOut.
  - A store grant produces dresp_valid = 1 and dresp_data = 0.
  - Each response valid is a one-cycle pulse. Consumers cannot stall.
- Fairness counter wait_cnt, $clog2(MAX_WAIT+1) bits:
  - Increments when ireq_valid && !ireq_ready.
  - Clears on a fetch grant or when ireq_valid is low.
  - Saturates at MAX_WAIT.
- Same-address load during a store cannot occur: only one access is granted per cycle.

## Timing
- Latency: grant in cycle N, response valid in cycle N+1. Throughput is one access per cycle in total.
- Back-to-back grants to the same requester are allowed every cycle.
- Reset values: iresp_valid = 0, dresp_valid = 0, iresp_data = 0, dresp_data = 0, wait_cnt = 0.
- While reset is high: ireq_ready = 0, dreq_ready = 0, mem_writeEnable = 0. No memory write occurs.
- Reset asserted the cycle after a grant: the pending response is dropped, and the outputs read 0 on the next edge.
- A store granted in cycle N is visible to any read granted in cycle N+1 or later.

## Configuration
- MEMARB_FAIRNESS_EN defined: wait_cnt is present and the MAX_WAIT rule applies. Fetch wait is bounded to MAX_WAIT cycles.
- MEMARB_FAIRNESS_EN undefined: strict data priority. wait_cnt is not instantiated and MAX_WAIT is ignored. A continuous data stream can starve fetch indefinitely.

## Structure
- Shared package memarb_pkg:
  - Requester-select enum with values GNT_NONE, GNT_INSTR, GNT_DATA.
  - Default width constants.
- Optional sub-module memarb_fairness: wait counter plus force-fetch output. It is instantiated only under MEMARB_FAIRNESS_EN.
- The top level holds the grant logic, the memory drive and the response registers.

## Test plan
- Reset: hold reset for 3 cycles with both valids high, ireq_addr = 4, dreq_addr = 8.
  - Both readies stay 0 and mem_writeEnable stays 0.
  - iresp_valid and dresp_valid read 0 until 1 cycle after release.
- Single fetch: preload mem[5] = 32'hDEADBEEF, then ireq_valid with ireq_addr = 5 and no data request.
  - ireq_ready is high the same cycle.
  - The next cycle shows iresp_valid = 1 and iresp_data = 32'hDEADBEEF.
- Store then load: store 32'h1234 to address 7 in cycle N, then load address 7 in cycle N+1.
  - dresp_valid is high with data 0 in N+1.
  - dresp_valid is high with data 32'h1234 in N+2.
- Contention without fairness: both valids are high for 10 cycles.
  - dreq_ready is high all 10 cycles; ireq_ready is never high.
  - 10 dresp_valid pulses are produced.
- Contention with MEMARB_FAIRNESS_EN and MAX_WAIT = 3: both valids are held high.
  - The grant pattern repeats D,D,D,I.
  - iresp_valid is high 1 cycle after each fetch grant.
- Reset mid-operation: assert reset in the cycle after a load grant to mem[2] = 32'hA5A5.
  - dresp_valid is 0 on the next edge.
  - No response appears after release.

Source files
------------

// File: rtl/memarb_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
package memarb_pkg;

  localparam int DEFAULT_ADDR_W   = 32;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_MAX_WAIT = 3;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } grant_e;

  // Width of a counter that must hold 0..max_wait inclusive.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/memarb_fairness.sv
// Anti-starvation counter: counts cycles a pending fetch has lost arbitration
// and raises force_fetch once it has waited MAX_WAIT cycles.
module memarb_fairness
  import memarb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq_valid,
  input  logic ireq_ready,
  output logic force_fetch
);

  localparam int CW = wait_cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!ireq_valid || ireq_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign force_fetch = ireq_valid && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Define MEMARB_FAIRNESS_EN to bound fetch starvation to MAX_WAIT lost cycles.
module memory_arbiter
  import memarb_pkg::*;
#(
  parameter int addresswidth = DEFAULT_ADDR_W,
  parameter int width        = DEFAULT_DATA_W,
  parameter int MAX_WAIT     = DEFAULT_MAX_WAIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ireq_valid,
  input  logic [addresswidth-1:0] ireq_addr,
  output logic                    ireq_ready,
  output logic                    iresp_valid,
  output logic [width-1:0]        iresp_data,
  input  logic                    dreq_valid,
  input  logic                    dreq_we,
  input  logic [addresswidth-1:0] dreq_addr,
  input  logic [width-1:0]        dreq_wdata,
  output logic                    dreq_ready,
  output logic                    dresp_valid,
  output logic [width-1:0]        dresp_data,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [width-1:0]        mem_dataIn,
  input  logic [width-1:0]        mem_dataOut
);

  // Handshake: a request transfers in the cycle where valid && ready. The
  // requester holds valid and payload until it sees ready; ready is
  // combinational and at most one ready is high per cycle. Responses are
  // one-cycle pulses in the cycle after the grant and cannot be stalled.

  grant_e gnt;
  logic   force_fetch;

`ifdef MEMARB_FAIRNESS_EN
  memarb_fairness #(
    .MAX_WAIT (MAX_WAIT)
  ) u_fairness (
    .clk         (clk),
    .reset       (reset),
    .ireq_valid  (ireq_valid),
    .ireq_ready  (ireq_ready),
    .force_fetch (force_fetch)
  );
`else
  // Strict data priority: a fetch is never forced ahead of a data request.
  assign force_fetch = (MAX_WAIT < 0);
`endif

  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (ireq_valid && (force_fetch || !dreq_valid)) begin
        gnt = GNT_INSTR;
      end else if (dreq_valid) begin
        gnt = GNT_DATA;
      end
    end
  end

  assign ireq_ready = (gnt == GNT_INSTR);
  assign dreq_ready = (gnt == GNT_DATA);

  // The data address is the idle default so a store path never glitches
  // through a fetch address.
  assign mem_address     = (gnt == GNT_INSTR) ? ireq_addr : dreq_addr;
  assign mem_writeEnable = dreq_ready && dreq_we;
  assign mem_dataIn      = dreq_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      iresp_valid <= 1'b0;
      iresp_data  <= '0;
      dresp_valid <= 1'b0;
      dresp_data  <= '0;
    end else begin
      iresp_valid <= (gnt == GNT_INSTR);
      dresp_valid <= (gnt == GNT_DATA);
      if (gnt == GNT_INSTR) begin
        iresp_data <= mem_dataOut;
      end
      if (gnt == GNT_DATA) begin
        dresp_data <= dreq_we ? '0 : mem_dataOut;
      end
    end
  end

endmodule
